pdm_decimator: RTL and testbench
================================

// Module: pdm_decimator
//
// PURPOSE
// Receive-side counterpart of the PDM output modulator: recovers a multi-bit
// amplitude sample stream from a 1-bit pulse-density bitstream (e.g. a PDM
// mic or a loopback of the pdm dout pin). Third-order CIC decimator (3
// integrators, decimate by 2**DECIM_LOG2, 3 combs), saturated and
// range-mapped onto an unsigned amplitude word with a one-cycle valid strobe.
//
// PARAMETERS
// NBITS      24  output sample width (AMPLITUDE_BITS); require NBITS <= 3*DECIM_LOG2
// DECIM_LOG2 8   log2 of decimation ratio R (R=256 -> 192 kHz from 49.152 MHz bitstream)
//
// PORTS
// clock       in   1      single clock; every register is on its rising edge
// reset_n     in   1      asynchronous, active-low reset
// din_valid   in   1      qualifies din; one PDM bit is accepted per cycle while high
// din         in   1      PDM bit, synchronous to clock (upstream synchronises pins)
// dout        out  NBITS  recovered unsigned amplitude; 0 = all-zeros, max = all-ones
// dout_valid  out  1      one-cycle pulse when dout carries a new sample
//
// BEHAVIOUR
// - Reset (reset_n low, async): integrators, comb delays, decimation counter,
//   dout=0, dout_valid=0. Reset mid-period discards the partial period; the
//   first output after release needs a full R accepted bits.
// - Internal width W = 3*DECIM_LOG2+1 (25 by default); all integrator/comb
//   arithmetic is modulo 2**W (wrap is intended, must not be saturated).
// - Input mapping: din=1 -> +1, din=0 -> 0 (unsigned CIC, gain R**3).
// - Integrators: on each cycle with din_valid=1, i1+=din; i2+=i1_new; i3+=i2_new
//   (cascaded, all updated in the same edge). din_valid=0: all hold.
// - Decimation counter: DECIM_LOG2 bits, increments per accepted bit; the
//   edge where it wraps R-1 -> 0 sets internal tick for the next cycle.
// - Comb stage, on the cycle tick is high: c1=i3-d1, c2=c1-d2, c3=c2-d3
//   (combinational), d1<=i3, d2<=c1, d3<=c2, i.e. differential delay M=1.
// - Output: y=c3 in [0, 2**(3*DECIM_LOG2)]; s = y >> (3*DECIM_LOG2-NBITS);
//   dout <= (s >= 2**NBITS) ? all-ones : s[NBITS-1:0]; dout_valid <= 1.
//   dout holds between strobes; dout_valid low otherwise.
// - Latency: dout_valid rises on the edge one cycle after the edge that
//   accepted the R-th bit of the period. din_valid may stay high during the
//   comb cycle; the new bit goes to the next period with no loss.
// - Output rate = accepted-bit rate / R; gaps in din_valid stretch the period
//   but do not change values.
// - Startup transient: outputs 1 and 2 after reset are partial (filter length
//   3R-2); outputs from the 3rd onward are settled.
//
// TESTING
// 1 All-ones, din_valid=1 from reset (R=256, NBITS=24) -> dout_valid every 256
//   cycles; outputs 0x2B2B00, 0xD5D500, then 0xFFFFFF (saturated) thereafter.
// 2 All-zeros -> every dout = 0x000000; dout_valid spacing exactly 256 cycles.
// 3 Alternating 1,0,1,0 -> from 3rd output onward dout = 0x800000 exactly.
// 4 Pattern of test 3 with din_valid pseudo-random 50% duty -> same dout
//   sequence as test 3; strobes spaced by 256 accepted bits, not cycles.
// 5 Loopback: pdm modulator (NBITS=24) fed constant 0x400000 -> settled dout
//   within +-0x000400 of 0x400000; first strobe 257 cycles after reset release.
// 6 reset_n pulsed low mid-period (async, between edges) -> dout=0, dout_valid=0
//   immediately; after release, test 1 sequence restarts from 0x2B2B00.

Source files
------------

// File: rtl/pdm_decimator.sv
// pdm_decimator: third-order CIC decimator that turns a 1-bit PDM stream into
// unsigned NBITS-wide amplitude samples. It has three integrators running at
// the bit rate, a decimation by 2**DECIM_LOG2, and three combs (M=1) running
// at the sample rate. The result is saturated and shifted onto NBITS bits.
//
// Handshake: din is consumed on every rising clock edge where din_valid is
// high, and there is no back-pressure. dout_valid is a single-cycle strobe.
// dout keeps its value between strobes.
module pdm_decimator #(
  parameter int NBITS      = 24,
  parameter int DECIM_LOG2 = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             din_valid,
  input  logic             din,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid
);

  // Internal width covers the full gain R**3 plus one bit.
  // Integrator and comb arithmetic wraps modulo 2**W on purpose.
  localparam int W     = 3*DECIM_LOG2 + 1;
  localparam int SHIFT = 3*DECIM_LOG2 - NBITS;

  logic [W-1:0]          i1, i2, i3;
  logic [W-1:0]          i1_nxt, i2_nxt, i3_nxt;
  logic [W-1:0]          d1, d2, d3;
  logic [W-1:0]          c1, c2, c3;
  logic [DECIM_LOG2-1:0] cnt;
  logic                  tick;
  logic [NBITS:0]        s;

  // Cascaded integrator update: each stage adds the freshly updated stage before it.
  always_comb begin
    i1_nxt = i1 + {{(W-1){1'b0}}, din};
    i2_nxt = i2 + i1_nxt;
    i3_nxt = i3 + i2_nxt;
  end

  // Integrators advance only on accepted bits and hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else if (din_valid) begin
      i1 <= i1_nxt;
      i2 <= i2_nxt;
      i3 <= i3_nxt;
    end
  end

  // Decimation counter. tick is high for the one cycle after the R-th accepted bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (din_valid) cnt <= cnt + 1'b1;
      tick <= din_valid && (cnt == '1);
    end
  end

  // Comb differences at the decimated rate. s keeps one guard bit above NBITS
  // so that a full-scale result of exactly 2**NBITS can be detected.
  always_comb begin
    c1 = i3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
    s  = c3[W-1:SHIFT];
  end

  // Comb delay registers load only on tick, giving a differential delay of one sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (tick) begin
      d1 <= i3;
      d2 <= c1;
      d3 <= c2;
    end
  end

  // Output register: saturate the full-scale case to all-ones and strobe valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= tick;
      if (tick) dout <= s[NBITS] ? {NBITS{1'b1}} : s[NBITS-1:0];
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: directed checks of the PDM CIC decimator at its default
// parameters (R=256, NBITS=24).
module tb_pdm_decimator;

  logic        clock;
  logic        reset_n;
  logic        din_valid;
  logic        din;
  logic [23:0] dout;
  logic        dout_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard state
  logic [23:0] exp_q[$];
  int          mode;       // 0 ones, 1 zeros, 2 alt, 3 alt+gaps, 4 sigma-delta 1/4
  int          skip_n;     // leading strobes whose value is not checked
  int          strobe_n;
  int          acc_n;      // accepted bits since reset
  int          cyc;        // cycles since reset release
  int          last_cyc;
  logic [23:0] sd_acc;

  pdm_decimator #(.NBITS(24), .DECIM_LOG2(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .din_valid  (din_valid),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, then sample #1 after the rising edge and score any strobe.
  task automatic step(input logic v);
    logic        b;
    logic [24:0] sd_sum;
    int          diff;
    sd_sum = {1'b0, sd_acc} + 25'h0400000;
    case (mode)
      0:       b = 1'b1;
      1:       b = 1'b0;
      2, 3:    b = (acc_n % 2 == 0);
      default: b = sd_sum[24];
    endcase
    din_valid = v;
    din       = b;
    @(posedge clock);
    #1;
    cyc++;
    if (dout_valid) begin
      chk("spacing_bits", acc_n, (strobe_n + 1) * 256);
      if (mode <= 1 && strobe_n > 0) chk("spacing_cycles", cyc - last_cyc, 256);
      if (mode == 0 && strobe_n == 0) chk("first_latency", cyc, 257);
      if (strobe_n >= skip_n) begin
        if (mode == 4) begin
          diff = int'(dout) - 32'h400000;
          if (diff < 0) diff = -diff;
          chk("loopback_tol", int'(diff <= 32'h400), 1);
        end else if (exp_q.size() > 0) begin
          chk("dout", int'(dout), int'(exp_q.pop_front()));
        end
      end
      last_cyc = cyc;
      strobe_n++;
    end
    if (v) begin
      acc_n++;
      if (mode == 4) sd_acc = sd_sum[23:0];
    end
  endtask

  task automatic do_reset(input int m, input int skip);
    din_valid = 1'b0;
    din       = 1'b0;
    reset_n   = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("reset_dout", int'(dout), 0);
    chk("reset_valid", int'(dout_valid), 0);
    exp_q.delete();
    mode     = m;
    skip_n   = skip;
    strobe_n = 0;
    acc_n    = 0;
    cyc      = 0;
    last_cyc = 0;
    sd_acc   = '0;
    reset_n  = 1'b1;
  endtask

  task automatic run_strobes(input int n, input bit rnd);
    int budget;
    budget = n * 256 * 3 + 64;
    while (strobe_n < n && budget > 0) begin
      step(rnd ? ($urandom_range(0, 1) != 0) : 1'b1);
      budget--;
    end
    chk("strobe_count", strobe_n, n);
  endtask

  // Directed sequence
  initial begin
    reset_n   = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    mode      = 0;
    sd_acc    = '0;

    // All ones: the two partial outputs, then saturation.
    do_reset(0, 0);
    exp_q.push_back(24'h2B2B00);
    exp_q.push_back(24'hD5D500);
    exp_q.push_back(24'hFFFFFF);
    exp_q.push_back(24'hFFFFFF);
    run_strobes(4, 1'b0);

    // Asynchronous reset between edges while dout holds 0xFFFFFF.
    for (int k = 0; k < 100; k++) step(1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_dout", int'(dout), 0);
    chk("async_reset_valid", int'(dout_valid), 0);
    #2;
    // After release the all-ones sequence restarts from the beginning.
    do_reset(0, 0);
    exp_q.push_back(24'h2B2B00);
    exp_q.push_back(24'hD5D500);
    exp_q.push_back(24'hFFFFFF);
    run_strobes(3, 1'b0);

    // All zeros
    do_reset(1, 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(24'h000000);
    run_strobes(4, 1'b0);

    // Alternating 1,0: settled mid-scale
    do_reset(2, 2);
    for (int k = 0; k < 3; k++) exp_q.push_back(24'h800000);
    run_strobes(5, 1'b0);

    // Same pattern with a pseudo-random 50% duty on din_valid
    do_reset(3, 2);
    for (int k = 0; k < 3; k++) exp_q.push_back(24'h800000);
    run_strobes(5, 1'b1);

    // Loopback of a first-order modulator fed 0x400000
    do_reset(4, 2);
    run_strobes(5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
